// File: rtl/uart_tx_arbiter_pkg.sv
// arb_defs: shared state encoding and limits for the UART transmitter arbiter.
package arb_defs;

    localparam int NREQ_MAX    = 4;
    localparam int TIMEOUT_DEF = 65535;
    localparam int PTR_W       = $clog2(NREQ_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        DONE
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, first set req bit at or above ptr, wrapping.
module rr_picker
    import arb_defs::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick
);

    int   pos;
    logic found;

    // Wrap by compare so non power-of-2 NREQ never aliases onto a missing requester.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NREQ)
                pos = pos - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && pos == i) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-atomic round-robin sharing of one RS232 transmitter between NREQ requesters.
// Optional ARB_TIMEOUT_EN: a frame whose owner stalls TIMEOUT cycles in SEND is aborted and released.
module uart_tx_arbiter
    import arb_defs::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   bvalid,
    input  logic [NREQ*8-1:0] bdata,
    input  logic [NREQ-1:0]   blast,
    output logic [NREQ-1:0]   back,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        txdw,
    output logic              txena,
    input  logic              txbusy,
    output logic              abort
);

    if (NREQ < 2 || NREQ > NREQ_MAX || TIMEOUT < 1) begin : g_cfg_check
        $error("uart_tx_arbiter: NREQ must be 2..4 and TIMEOUT >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d, back_q, back_d, pick;
    logic [7:0]       txdw_q, txdw_d, sel_data;
    logic             txena_q, txena_d, last_q, last_d;
    logic [PTR_W-1:0] rr_q, rr_d, owner, rr_next;
    logic             sel_valid, sel_last, accept;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          abort_q, abort_d;
`endif

    rr_picker #(.NREQ(NREQ)) u_pick (
        .req  (req),
        .ptr  (rr_q),
        .pick (pick)
    );

    // Byte-lane mux driven by the registered one-hot owner.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        owner     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                sel_valid = bvalid[i];
                sel_last  = blast[i];
                sel_data  = bdata[8*i +: 8];
                owner     = PTR_W'(i);
            end
        end
    end

    assign accept  = sel_valid && !txbusy;
    assign rr_next = (int'(owner) + 1 >= NREQ) ? '0 : owner + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        last_d  = last_q;
        txdw_d  = txdw_q;
        txena_d = 1'b0;
        back_d  = '0;
`ifdef ARB_TIMEOUT_EN
        timer_d = timer_q;
        abort_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    txdw_d  = sel_data;
                    txena_d = 1'b1;
                    back_d  = gnt_q;
                    last_d  = sel_last;
                    state_d = WAIT_HI;
                end
`ifdef ARB_TIMEOUT_EN
                if (accept)
                    timer_d = '0;
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    timer_d = '0;
                    state_d = DONE;
                end else
                    timer_d = timer_q + TW'(1);
`endif
            end
            WAIT_HI: if (txbusy) state_d = WAIT_LO;
            WAIT_LO: if (!txbusy) state_d = last_q ? DONE : SEND;
            DONE: begin
                gnt_d   = '0;
                rr_d    = rr_next;
                state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            back_q  <= '0;
            rr_q    <= '0;
            last_q  <= 1'b0;
            txdw_q  <= 8'h00;
            txena_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timer_q <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            back_q  <= back_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            txdw_q  <= txdw_d;
            txena_q <= txena_d;
`ifdef ARB_TIMEOUT_EN
            timer_q <= timer_d;
            abort_q <= abort_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign back  = back_q;
    assign txdw  = txdw_q;
    assign txena = txena_q;
`ifdef ARB_TIMEOUT_EN
    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester frame queues, a 10-cycle transmitter model and a
// round-robin grant model; directed scenarios followed by randomized traffic.
module tb_uart_tx_arbiter;

    localparam int N    = 3;
    localparam int TMO  = 20;
    localparam int BUSY = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0, bvalid = '0, blast = '0;
    logic [N*8-1:0] bdata = '0;
    logic [N-1:0]   back, gnt;
    logic [7:0]     txdw;
    logic           txena, abort;
    logic           txbusy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .bvalid(bvalid), .bdata(bdata), .blast(blast),
        .back(back), .gnt(gnt), .txdw(txdw), .txena(txena), .txbusy(txbusy), .abort(abort)
    );

    int total = 0, bad = 0, cyc = 0;
    logic [7:0] fq [N][$];
    logic [N-1:0] drop_req = '0, stall_mask = '0, noise = '0;
    bit   rnd = 0, ext_busy = 0, aborted = 0;
    int   busy_cnt = 0, rr_m = 0, abort_at = -1;
    int   stall_run [N];
    int   nback [N];
    logic [7:0]   sent [$];
    int           sent_t [$];
    logic [N-1:0] glog [$];
    int           glog_t [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
        return -1;
    endfunction

    // Round-robin rule: first pending requester counting up from the pointer, modulo N.
    function automatic logic [N-1:0] pick_m(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int j = (p + k) % N;
            if (r[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (fq[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic drive();
        logic [N-1:0]   rq = '0, bv = '0, bl = '0;
        logic [N*8-1:0] bd = '0;
        for (int i = 0; i < N; i++) begin
            bit has = fq[i].size() > 0;
            bit v   = has && !stall_mask[i];
            if (v && rnd && $urandom_range(0, 3) == 0 && stall_run[i] < 6) v = 0;
            stall_run[i] = (has && !v) ? stall_run[i] + 1 : 0;
            if (!has && noise[i]) v = (cyc % 2) == 1;
            if (has && !(gnt[i] && drop_req[i])) rq[i] = 1'b1;
            bv[i] = v;
            bl[i] = fq[i].size() == 1;
            bd[8*i +: 8] = has ? fq[i][0] : 8'($urandom);
        end
        req = rq; bvalid = bv; blast = bl; bdata = bd;
    endtask

    task automatic tick();
        logic [N-1:0] p_req = req, p_bv = bvalid, p_gnt = gnt;
        logic         p_busy = txbusy;
        int           o;
        @(posedge clk); #1;
        cyc++;
        chk("gnt_onehot", 32'($onehot0(gnt)), 1);
        chk("abort", 32'(abort), 32'(cyc == abort_at));
        if (abort) aborted = 1;
        if (p_gnt == '0) begin
            chk("gnt_pick", 32'(gnt), 32'(pick_m(p_req, rr_m)));
            if (gnt != '0) begin glog.push_back(gnt); glog_t.push_back(cyc); end
        end else if (gnt != p_gnt) begin
            o = idx_of(p_gnt);
            chk("gnt_release", 32'(gnt), 0);
            chk("frame_end", 32'(fq[o].size() == 0 || aborted), 1);
            if (aborted) begin fq[o].delete(); aborted = 0; end
            rr_m = (o + 1) % N;
        end
        if (txena) begin
            o = idx_of(gnt);
            chk("back", 32'(back), 32'(gnt));
            chk("tx_when_idle", 32'(p_busy), 0);
            chk("tx_owner", 32'(o >= 0 && fq[o].size() > 0), 1);
            if (o >= 0 && fq[o].size() > 0) begin
                chk("tx_bvalid", 32'(p_bv[o]), 1);
                chk("txdw", 32'(txdw), 32'(fq[o][0]));
                void'(fq[o].pop_front());
                nback[o]++;
            end
            sent.push_back(txdw);
            sent_t.push_back(cyc);
        end else
            chk("back_idle", 32'(back), 0);
        // Transmitter: busy from the cycle after txena for BUSY cycles.
        if (rnd) ext_busy = ($urandom_range(0, 15) == 0);
        if (busy_cnt > 0) busy_cnt--;
        if (txena) busy_cnt = BUSY;
        txbusy = ext_busy || busy_cnt > 0;
        drive();
    endtask

    task automatic clear_logs();
        sent.delete(); sent_t.delete(); glog.delete(); glog_t.delete();
        for (int i = 0; i < N; i++) nback[i] = 0;
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin fq[i].delete(); stall_run[i] = 0; end
        busy_cnt = 0; ext_busy = 0; txbusy = 1'b0; rr_m = 0; aborted = 0; abort_at = -1;
        stall_mask = '0; noise = '0; drop_req = '0;
        drive();
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_txena", 32'(txena), 0);
        chk("rst_back", 32'(back), 0);
        chk("rst_txdw", 32'(txdw), 0);
        chk("rst_abort", 32'(abort), 0);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(gnt), 0);
        chk("rst_hold_txena", 32'(txena), 0);
        rst = 1'b1;
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n = 0;
        do begin tick(); n++; end while ((pending() || gnt != '0) && n < budget);
        chk(tag, 32'(n < budget), 1);
    endtask

    initial begin
        logic [N-1:0] exp_g [5];
        logic [7:0]   exp_s [7];
        int n;

        do_reset(2);

        // 1: single 3-byte frame from requester 0
        clear_logs();
        fq[0] = '{8'hA5, 8'h5A, 8'hFF};
        drive();
        run_idle(200, "t1_done");
        chk("t1_nbytes", 32'(sent.size()), 3);
        chk("t1_b0", 32'(sent[0]), 32'hA5);
        chk("t1_b1", 32'(sent[1]), 32'h5A);
        chk("t1_b2", 32'(sent[2]), 32'hFF);
        chk("t1_back0", 32'(nback[0]), 3);
        chk("t1_grants", 32'(glog.size()), 1);
        chk("t1_gnt", 32'(glog[0]), 1);
        chk("t1_req_to_gnt", 32'(glog_t[0]), 1);
        chk("t1_gnt_to_tx", 32'(sent_t[0] - glog_t[0]), 1);
        chk("t1_gap1", 32'(sent_t[1] - sent_t[0]), BUSY + 2);
        chk("t1_gap2", 32'(sent_t[2] - sent_t[1]), BUSY + 2);
        chk("t1_gnt_end", 32'(gnt), 0);

        // 2: simultaneous requests; frames stay whole and grants rotate with wrap past N-1
        do_reset(1);
        clear_logs();
        fq[0] = '{8'h11, 8'h12};
        fq[1] = '{8'h21, 8'h22};
        drive();
        run_idle(400, "t2a_done");
        fq[0] = '{8'h31}; fq[1] = '{8'h41}; fq[2] = '{8'h51};
        drive();
        run_idle(400, "t2b_done");
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        exp_s = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h51, 8'h31, 8'h41};
        chk("t2_grants", 32'(glog.size()), 5);
        for (int k = 0; k < 5; k++) chk("t2_gnt_order", 32'(glog[k]), 32'(exp_g[k]));
        chk("t2_nbytes", 32'(sent.size()), 7);
        for (int k = 0; k < 7; k++) chk("t2_byte_order", 32'(sent[k]), 32'(exp_s[k]));

        // 3: idle requester toggles bvalid while another owns the transmitter
        clear_logs();
        noise = 3'b010;
        fq[0] = '{8'hC1, 8'hC2, 8'hC3};
        drive();
        run_idle(200, "t3_done");
        noise = '0;
        chk("t3_back1", 32'(nback[1]), 0);
        chk("t3_nbytes", 32'(sent.size()), 3);
        chk("t3_b2", 32'(sent[2]), 32'hC3);

        // 4: reset while waiting for byte 2 to finish; pointer returns to 0
        do_reset(1);
        fq[0] = '{8'h01};
        drive();
        run_idle(100, "t4a_done");
        clear_logs();
        fq[1] = '{8'hD1, 8'hD2, 8'hD3};
        drive();
        n = 0;
        while (sent.size() < 2 && n < 100) begin tick(); n++; end
        chk("t4_byte2_seen", 32'(n < 100), 1);
        repeat (5) tick();
        do_reset(1);
        tick();
        chk("t4_gnt_after", 32'(gnt), 0);
        chk("t4_txena_after", 32'(txena), 0);
        clear_logs();
        fq[0] = '{8'hE1}; fq[1] = '{8'hE2};
        drive();
        run_idle(200, "t4b_done");
        chk("t4_first_gnt", 32'(glog[0]), 1);
        chk("t4_nbytes", 32'(sent.size()), 2);
        chk("t4_b0", 32'(sent[0]), 32'hE1);
        chk("t4_b1", 32'(sent[1]), 32'hE2);

        // 6: transmitter already busy at grant
        clear_logs();
        ext_busy = 1; txbusy = 1'b1;
        fq[0] = '{8'h66};
        drive();
        repeat (15) tick();
        chk("t6_no_tx", 32'(sent.size()), 0);
        chk("t6_gnt", 32'(gnt), 1);
        ext_busy = 0;
        run_idle(100, "t6_done");
        chk("t6_one_tx", 32'(sent.size()), 1);
        chk("t6_byte", 32'(sent[0]), 32'h66);

`ifdef ARB_TIMEOUT_EN
        // 5: owner stalls after byte 1; abort after TMO cycles in SEND, then next requester
        do_reset(1);
        clear_logs();
        fq[0] = '{8'h71, 8'h72, 8'h73};
        fq[1] = '{8'h81};
        drive();
        n = 0;
        while (sent.size() < 1 && n < 50) begin tick(); n++; end
        chk("t5_byte1_seen", 32'(n < 50), 1);
        stall_mask = 3'b001;
        abort_at = sent_t[0] + 1 + BUSY + TMO;
        drive();
        run_idle(300, "t5_done");
        stall_mask = '0;
        chk("t5_grants", 32'(glog.size()), 2);
        chk("t5_gnt1", 32'(glog[1]), 32'b010);
        chk("t5_gnt1_time", 32'(glog_t[1]), 32'(abort_at + 2));
        chk("t5_nbytes", 32'(sent.size()), 2);
        chk("t5_b1", 32'(sent[1]), 32'h81);
        abort_at = -1;
`endif

        // Randomized traffic: frames of 1..4 bytes, stalls, req drops, noise and busy pulses
        clear_logs();
        rnd = 1; noise = '1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (fq[i].size() == 0 && !gnt[i] && $urandom_range(0, 9) == 0) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) fq[i].push_back(8'($urandom));
                    drop_req[i] = ($urandom_range(0, 3) == 0);
                end
            end
            drive();
        end
        run_idle(2000, "rnd_drain");
        rnd = 0; ext_busy = 0; noise = '0;
        chk("rnd_traffic", 32'(sent.size() > 50), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
